// File: rtl/sim_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_queue_pkg
// Description : Shared constants and types for the simulation queue models.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_queue_pkg;

    localparam logic [7:0] CMD_FINISHED    = 8'h03;

    localparam int         VALID_BIT       = 63;
    localparam int         ACC_LSB         = 16;
    localparam int         CODE_LSB        = 0;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [63:0] header;
        logic [63:0] task_id;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/cmd_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : cmd_queue_mem
// Description : Single-port 64-bit memory, byte write enables, 1-cycle read.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_queue_mem #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wstrb,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] r_mem [DEPTH];

    // rdata only moves on a read so a held result survives intervening writes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    if (wstrb[b]) begin
                        r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= r_mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_out_queue_sink.sv
`default_nettype none
// ============================================================================
// Module      : cmd_out_queue_sink
// Description : AXI4-Lite command-out queue memory that pops finished entries.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_out_queue_sink
    import sim_queue_pkg::*;
#(
    parameter int          NUM_SLOTS   = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter logic [7:0]  FINISH_CODE = CMD_FINISHED
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [63:0] done_task_id,
    output logic [7:0]  done_accel_id,
    output logic [31:0] done_count,
    output logic        bad_cmd
);

    localparam int          IDX_W        = $clog2(NUM_SLOTS);
    localparam int          MEM_AW       = IDX_W + 1;
    localparam logic [31:0] REGION_BYTES = 32'(NUM_SLOTS * 16);

    localparam logic [1:0] ST_SCAN  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    logic              r_run;
    logic              r_aw_full, r_w_full, r_ar_pend;
    logic [31:0]       r_awaddr, r_araddr;
    logic [63:0]       r_wdata, r_rdata;
    logic [7:0]        r_wstrb, r_code;
    logic              r_rd_live, r_rd_ok;
    logic [1:0]        r_state;
    logic              r_pend;
    logic [IDX_W-1:0]  r_idx;

    logic              w_wr_go, w_rd_go, w_sc_go, w_sc_req, w_ar_hs, w_rd_req;
    logic [31:0]       w_aw_off, w_rd_off, w_rd_addr;
    logic              w_aw_ok, w_rd_ok;
    logic              mem_we, mem_re;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wstrb;
    logic [63:0]       mem_wdata, mem_rdata;
    logic              w_unused;

    // Unsigned wrap makes addresses below BASE_ADDR fail the same compare
    assign w_aw_off  = r_awaddr - BASE_ADDR;
    assign w_aw_ok   = w_aw_off < REGION_BYTES;
    assign w_rd_addr = r_ar_pend ? r_araddr : s_axi_araddr;
    assign w_rd_off  = w_rd_addr - BASE_ADDR;
    assign w_rd_ok   = w_rd_off < REGION_BYTES;

    assign s_axi_awready = r_run && !r_aw_full && !s_axi_bvalid;
    assign s_axi_wready  = r_run && !r_w_full  && !s_axi_bvalid;
    assign s_axi_arready = r_run && !r_ar_pend && !s_axi_rvalid;
    assign s_axi_rdata   = r_rd_live ? (r_rd_ok ? mem_rdata : 64'd0) : r_rdata;

    assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
    assign w_wr_go  = r_aw_full && r_w_full;
    assign w_rd_req = r_ar_pend || w_ar_hs;
    assign w_rd_go  = w_rd_req && !w_wr_go;
    assign w_sc_req = ((r_state == ST_SCAN || r_state == ST_FETCH) && !r_pend)
                      || (r_state == ST_CLEAR);
    assign w_sc_go  = w_sc_req && !w_wr_go && !w_rd_go;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, w_aw_off[31:MEM_AW+3], w_aw_off[2:0],
                        w_rd_off[31:MEM_AW+3], w_rd_off[2:0]};

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (w_wr_go) begin
            mem_we    = w_aw_ok;
            mem_addr  = w_aw_off[MEM_AW+2:3];
            mem_wstrb = r_wstrb;
            mem_wdata = r_wdata;
        end else if (w_rd_go) begin
            mem_re    = w_rd_ok;
            mem_addr  = w_rd_off[MEM_AW+2:3];
        end else if (w_sc_go) begin
            mem_addr  = {r_idx, (r_state == ST_FETCH)};
            mem_re    = (r_state != ST_CLEAR);
            mem_we    = (r_state == ST_CLEAR);
            mem_wstrb = 8'hFF;
        end
    end

    cmd_queue_mem #(
        .DEPTH (2 * NUM_SLOTS),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wstrb (mem_wstrb),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run        <= 1'b0;
            r_aw_full    <= 1'b0;
            r_w_full     <= 1'b0;
            r_ar_pend    <= 1'b0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
            r_rd_live    <= 1'b0;
            r_rd_ok      <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= AXI_RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= AXI_RESP_OKAY;
        end else begin
            r_run <= 1'b1;
            if (s_axi_awvalid && s_axi_awready) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_wr_go) begin
                r_aw_full    <= 1'b0;
                r_w_full     <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= w_aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (w_ar_hs && !w_rd_go) begin
                r_ar_pend <= 1'b1;
                r_araddr  <= s_axi_araddr;
            end
            // The memory output is live for one cycle, then frozen in r_rdata
            if (w_rd_go) begin
                r_ar_pend    <= 1'b0;
                r_rd_live    <= 1'b1;
                r_rd_ok      <= w_rd_ok;
                s_axi_rvalid <= 1'b1;
                s_axi_rresp  <= w_rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else begin
                if (r_rd_live) begin
                    r_rd_live <= 1'b0;
                    r_rdata   <= s_axi_rdata;
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    s_axi_rvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_SCAN;
            r_pend        <= 1'b0;
            r_idx         <= '0;
            r_code        <= '0;
            done_valid    <= 1'b0;
            done_task_id  <= '0;
            done_accel_id <= '0;
            done_count    <= '0;
            bad_cmd       <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_pend) begin
                        r_pend <= 1'b0;
                        if (mem_rdata[VALID_BIT]) begin
                            done_accel_id <= mem_rdata[ACC_LSB +: 8];
                            r_code        <= mem_rdata[CODE_LSB +: 8];
                            r_state       <= ST_FETCH;
                        end
                    end else if (w_sc_go) begin
                        r_pend <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (r_pend) begin
                        r_pend       <= 1'b0;
                        done_task_id <= mem_rdata;
                        done_valid   <= 1'b1;
                        r_state      <= ST_EMIT;
                        if (r_code != FINISH_CODE) begin
                            bad_cmd <= 1'b1;
                        end
                    end else if (w_sc_go) begin
                        r_pend <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        r_state    <= ST_CLEAR;
                    end
                end
                default: begin
                    if (w_sc_go) begin
                        done_count <= done_count + 32'd1;
                        r_idx      <= IDX_W'(r_idx + 1);
                        r_state    <= ST_SCAN;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
